// File: rtl/ifmap_framer_pkg.sv
// Shared constants and types for the IFmap buffer framer.
// The flag pair sits above the data bits: {start, end}.
package ifmap_framer_pkg;

    localparam int unsigned FLAG_WIDTH = 2;

    localparam logic [FLAG_WIDTH-1:0] FLAG_START  = 2'b10;
    localparam logic [FLAG_WIDTH-1:0] FLAG_MID    = 2'b00;
    localparam logic [FLAG_WIDTH-1:0] FLAG_END    = 2'b01;
    localparam logic [FLAG_WIDTH-1:0] FLAG_SINGLE = 2'b11;

    typedef enum logic {
        StPass  = 1'b0,
        StFlush = 1'b1
    } state_e;

    function automatic int unsigned frame_width(input int unsigned data_width);
        return data_width + FLAG_WIDTH;
    endfunction

endpackage

// File: rtl/ifmap_framer_fifo.sv
// Small synchronous FIFO holding framed words between the input stream and the
// output register; power-of-two depth so pointers wrap naturally.
module framer_fifo #(
    parameter int unsigned Width = 18,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/ifmap_framer.sv
// Frames raw ifmap samples into {start, end, data} buffer words and, on request,
// inserts a zero frame of filter_size words at the next frame boundary.
module ifmap_framer
    import ifmap_framer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH        = 16,
    parameter int unsigned FRAME_WIDTH       = frame_width(DATA_WIDTH),
    parameter int unsigned FILTER_SIZE_WIDTH = 5,
    parameter int unsigned FIFO_DEPTH        = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic                         in_valid,
    input  logic                         in_last,
    output logic                         in_ready,
    input  logic [FILTER_SIZE_WIDTH-1:0] filter_size,
    input  logic                         flush_req,
    output logic [FRAME_WIDTH-1:0]       out_data,
    output logic                         out_wen,
    input  logic                         out_ready,
    output logic                         busy
);

    localparam int unsigned EndBit   = DATA_WIDTH;
    localparam int unsigned StartBit = DATA_WIDTH + 1;
    localparam logic [FILTER_SIZE_WIDTH-1:0] FszOne = FILTER_SIZE_WIDTH'(1);

    state_e                       state_q, state_d;
    logic [FILTER_SIZE_WIDTH-1:0] fsz_q, fsz_d;
    logic [FILTER_SIZE_WIDTH-1:0] cnt_q, cnt_d;
    logic                         flush_pending_q, flush_pending_d;
    logic                         in_frame_q, in_frame_d;
    logic                         out_in_frame_q, out_in_frame_d;
    logic [FRAME_WIDTH-1:0]       out_q, out_d;
    logic                         out_wen_q, out_wen_d;
    logic                         in_ready_en_q;

    logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FRAME_WIDTH-1:0] fifo_head, fifo_wdata;
    logic                   out_xfer, out_load, go_flush;
    logic [FLAG_WIDTH-1:0]  flush_flags;

    assign in_ready   = in_ready_en_q & ~fifo_full;
    assign fifo_push  = in_valid & in_ready;
    assign fifo_wdata = {~in_frame_q, in_last, in_data};
    assign in_frame_d = fifo_push ? ~in_last : in_frame_q;

    assign out_xfer = out_wen_q & out_ready;
    assign out_load = out_xfer | ~out_wen_q;
    assign out_data = out_q;
    assign out_wen  = out_wen_q;
    assign busy     = ~fifo_empty | flush_pending_q | (state_q == StFlush) | out_wen_q;

    framer_fifo #(
        .Width (FRAME_WIDTH),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Frame state as seen downstream, including the word leaving on this edge.
    always_comb begin
        out_in_frame_d = out_in_frame_q;
        if (out_xfer) begin
            if (out_q[EndBit])        out_in_frame_d = 1'b0;
            else if (out_q[StartBit]) out_in_frame_d = 1'b1;
        end
    end

    always_comb begin
        if (fsz_q == FszOne)              flush_flags = FLAG_SINGLE;
        else if (cnt_q == '0)             flush_flags = FLAG_START;
        else if (cnt_q == fsz_q - FszOne) flush_flags = FLAG_END;
        else                              flush_flags = FLAG_MID;
    end

    always_comb begin
        state_d         = state_q;
        fsz_d           = fsz_q;
        cnt_d           = cnt_q;
        flush_pending_d = flush_pending_q;
        out_d           = out_q;
        out_wen_d       = out_wen_q & ~out_ready;
        fifo_pop        = 1'b0;
        go_flush        = 1'b0;
        unique case (state_q)
            StPass: begin
                if (flush_req && !flush_pending_q) flush_pending_d = 1'b1;
                if (flush_pending_q && out_load && !out_in_frame_d) begin
                    flush_pending_d = 1'b0;
                    // A zero-length flush is simply dropped.
                    if (filter_size != '0) begin
                        go_flush = 1'b1;
                        state_d  = StFlush;
                        fsz_d    = filter_size;
                        cnt_d    = '0;
                    end
                end
                if (out_load && !go_flush && !fifo_empty) begin
                    out_d     = fifo_head;
                    out_wen_d = 1'b1;
                    fifo_pop  = 1'b1;
                end
            end
            StFlush: begin
                if (out_load) begin
                    out_d     = {flush_flags, {DATA_WIDTH{1'b0}}};
                    out_wen_d = 1'b1;
                    cnt_d     = cnt_q + FszOne;
                    if (cnt_q == fsz_q - FszOne) state_d = StPass;
                end
            end
            default: state_d = StPass;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= StPass;
            fsz_q           <= '0;
            cnt_q           <= '0;
            flush_pending_q <= 1'b0;
            in_frame_q      <= 1'b0;
            out_in_frame_q  <= 1'b0;
            out_q           <= '0;
            out_wen_q       <= 1'b0;
            in_ready_en_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            fsz_q           <= fsz_d;
            cnt_q           <= cnt_d;
            flush_pending_q <= flush_pending_d;
            in_frame_q      <= in_frame_d;
            out_in_frame_q  <= out_in_frame_d;
            out_q           <= out_d;
            out_wen_q       <= out_wen_d;
            in_ready_en_q   <= 1'b1;
        end
    end

endmodule
